// File: rtl/clock_step_ctrl_if.sv
// Control/status bundle between the rate controller and the core/board.
// Inputs from switches, pushbutton and core; enable pulse and status back.
interface clock_step_ctrl_if;
  logic [1:0]  mode;
  logic        step_key;
  logic        halt_req;
  logic        cpu_en;
  logic [1:0]  state;
  logic [15:0] en_count;

  modport master (
    output mode,
    output step_key,
    output halt_req,
    input  cpu_en,
    input  state,
    input  en_count
  );

  modport slave (
    input  mode,
    input  step_key,
    input  halt_req,
    output cpu_en,
    output state,
    output en_count
  );
endinterface

// File: rtl/clock_step_ctrl.sv
// Issues a registered one-cycle cpu_en in fast/slow free-run or debounced single-step mode, with halt.
// Latency: mode pin -> state 3 cycles; no backpressure, pulses are never queued.
module clock_step_ctrl #(
  parameter int FAST_DIV_LOG2   = 6,
  parameter int SLOW_DIV_LOG2   = 25,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  clock_step_ctrl_if.slave bus
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SLOW_DIV_LOG2-1:0] FAST_MASK =
    SLOW_DIV_LOG2'((64'd1 << FAST_DIV_LOG2) - 64'd1);

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_FAST = 2'b01;
  localparam logic [1:0] MODE_SLOW = 2'b10;
  localparam logic [1:0] MODE_STEP = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  // Assert asynchronously, release on a clock edge.
  logic rst_q1;
  logic rst_n_s;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      rst_q1  <= 1'b0;
      rst_n_s <= 1'b0;
    end else begin
      rst_q1  <= 1'b1;
      rst_n_s <= rst_q1;
    end
  end

  logic [1:0] mode_q1;
  logic [1:0] mode_s;
  logic       key_q1;
  logic       key_s;

  always_ff @(posedge CLOCK_50 or negedge rst_n_s) begin
    if (!rst_n_s) begin
      mode_q1 <= MODE_IDLE;
      mode_s  <= MODE_IDLE;
      key_q1  <= 1'b1;
      key_s   <= 1'b1;
    end else begin
      mode_q1 <= bus.mode;
      mode_s  <= mode_q1;
      key_q1  <= bus.step_key;
      key_s   <= key_q1;
    end
  end

  logic [DB_W-1:0] db_cnt;
  logic            key_db;
  logic            key_db_d;
  logic            press;

  always_ff @(posedge CLOCK_50 or negedge rst_n_s) begin
    if (!rst_n_s) begin
      db_cnt   <= '0;
      key_db   <= 1'b1;
      key_db_d <= 1'b1;
    end else begin
      key_db_d <= key_db;
      if (key_s == key_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt <= '0;
        key_db <= key_s;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press = key_db_d & ~key_db;

  state_t                   state_q;
  state_t                   state_nxt;
  logic                     cpu_en_q;
  logic                     en_nxt;
  logic [15:0]              en_count_q;
  logic [SLOW_DIV_LOG2-1:0] presc;
  logic                     tick;
  logic                     rate_swap;

  assign tick = ((mode_s == MODE_FAST) && ((presc & FAST_MASK) == FAST_MASK)) ||
                ((mode_s == MODE_SLOW) && (&presc));

  // mode_q1 shows the rate change one cycle early so the restart lines up with mode_s.
  assign rate_swap = ((mode_s == MODE_FAST) && (mode_q1 == MODE_SLOW)) ||
                     ((mode_s == MODE_SLOW) && (mode_q1 == MODE_FAST));

  always_comb begin
    state_nxt = state_q;
    en_nxt    = 1'b0;
    if ((state_q != S_HALTED) && bus.halt_req) begin
      state_nxt = S_HALTED;
    end else begin
      case (state_q)
        S_HALTED: begin
          if (mode_s == MODE_IDLE) state_nxt = S_IDLE;
        end
        S_IDLE: begin
          if ((mode_s == MODE_FAST) || (mode_s == MODE_SLOW)) state_nxt = S_RUN;
          else if (mode_s == MODE_STEP)                        state_nxt = S_STEP;
        end
        S_RUN: begin
          if (mode_s == MODE_IDLE)      state_nxt = S_IDLE;
          else if (mode_s == MODE_STEP) state_nxt = S_STEP;
          en_nxt = tick & ~cpu_en_q;
        end
        S_STEP: begin
          if (mode_s == MODE_IDLE)                                  state_nxt = S_IDLE;
          else if ((mode_s == MODE_FAST) || (mode_s == MODE_SLOW)) state_nxt = S_RUN;
          en_nxt = press & ~cpu_en_q;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q    <= S_IDLE;
      cpu_en_q   <= 1'b0;
      en_count_q <= 16'd0;
    end else begin
      state_q  <= state_nxt;
      cpu_en_q <= en_nxt;
      if (en_nxt) en_count_q <= en_count_q + 16'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n_s) begin
    if (!rst_n_s) begin
      presc <= '0;
    end else if ((state_nxt != S_RUN) || (state_q != S_RUN) || rate_swap) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign bus.cpu_en   = cpu_en_q;
  assign bus.state    = state_q;
  assign bus.en_count = en_count_q;

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Randomized scoreboard bench for clock_step_ctrl: expected pulse times/counts are queued by
// the stimulus from the mode/press/halt timing rules and popped by a negedge monitor.
`timescale 1ns/1ps
module tb_clock_step_ctrl;
  localparam int FAST   = 2;
  localparam int SLOW   = 4;
  localparam int DB     = 4;
  localparam int FAST_P = 1 << FAST;
  localparam int SLOW_P = 1 << SLOW;

  logic CLOCK_50 = 1'b0;
  logic reset_n  = 1'b1;

  clock_step_ctrl_if bus ();

  clock_step_ctrl #(
    .FAST_DIV_LOG2  (FAST),
    .SLOW_DIV_LOG2  (SLOW),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int          lo;
    int          hi;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc       = 0;
  int          checks    = 0;
  int          errors    = 0;
  logic [15:0] model_cnt = 16'd0;
  bit          prev_en   = 1'b0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_pulse(input int lo, input int hi);
    exp_t e;
    model_cnt = model_cnt + 16'd1;
    e.lo  = lo;
    e.hi  = hi;
    e.cnt = model_cnt;
    exp_q.push_back(e);
  endtask

  task automatic drained(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic until_cyc(input int c);
    while (cyc < c) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  // Monitor: every observed pulse must match the head of the expectation queue.
  always @(negedge CLOCK_50) begin
    exp_t e;
    if (reset_n) begin
      if (bus.cpu_en) begin
        check("no_back_to_back", {31'd0, prev_en}, 0);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse actual=pulse required=none (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          if (cyc < e.lo || cyc > e.hi) begin
            errors++;
            $display("FAIL pulse_time actual=%0d required=%0d..%0d", cyc, e.lo, e.hi);
          end
          check("pulse_count", bus.en_count, e.cnt);
        end
      end
      prev_en = bus.cpu_en;
    end else begin
      prev_en = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int c, s, z, m, k, t, T, K, b, e, r;
    bus.mode     = 2'($urandom_range(0, 3));
    bus.step_key = 1'($urandom_range(0, 1));
    bus.halt_req = 1'($urandom_range(0, 1));
    #2 reset_n = 1'b0;

    // Reset with arbitrary inputs, then quiet release.
    cycles(2);
    check("rst_cpu_en", bus.cpu_en, 0);
    check("rst_state", bus.state, 0);
    check("rst_en_count", bus.en_count, 0);
    bus.mode = 2'b00; bus.step_key = 1'b1; bus.halt_req = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      check("idle_state", bus.state, 0);
      check("idle_en_count", bus.en_count, 0);
    end

    // Fast run, then switch to slow, then stop.
    c = cyc;
    bus.mode = 2'b01;
    s = c + 3 + 10 * FAST_P + $urandom_range(0, 7);
    for (t = c + 3 + FAST_P; t <= s + 2; t += FAST_P) expect_pulse(t, t);
    cycles(3);
    check("fast_entry_state", bus.state, 1);
    until_cyc(c + 3 + 10 * FAST_P);
    check("fast_count10", bus.en_count, 10);
    until_cyc(s);
    bus.mode = 2'b10;
    m = $urandom_range(2, 3);
    z = s + 2 + m * SLOW_P + $urandom_range(1, 10);
    for (t = s + 2 + SLOW_P; t <= z + 2; t += SLOW_P) expect_pulse(t, t);
    until_cyc(z);
    bus.mode = 2'b00;
    until_cyc(z + 3);
    check("slow_stop_state", bus.state, 0);
    cycles(40);
    drained("run_drain");

    // Single-step with bounces, held key, and a second press.
    bus.mode = 2'b11;
    cycles(3);
    check("step_state", bus.state, 2);
    cycles(2);
    for (int i = 0; i < 3; i++) begin
      bus.step_key = 1'b0; cycles($urandom_range(1, 2));
      bus.step_key = 1'b1; cycles($urandom_range(1, 2));
    end
    for (int p = 0; p < 2; p++) begin
      b = cyc;
      expect_pulse(b + 2 + DB + 2 - 1, b + 2 + DB + 2 + 1);
      bus.step_key = 1'b0; cycles($urandom_range(12, 16));
      bus.step_key = 1'b1; cycles(8);
    end
    drained("step_drain");
    check("step_en_count", bus.en_count, model_cnt);

    // A press in IDLE is discarded.
    bus.mode = 2'b00;
    cycles(4);
    check("idle_again_state", bus.state, 0);
    bus.step_key = 1'b0; cycles(12);
    bus.step_key = 1'b1; cycles(8);
    drained("idle_press_drain");
    check("idle_press_count", bus.en_count, model_cnt);

    // Halt coinciding with a tick.
    c = cyc;
    bus.mode = 2'b01;
    K = $urandom_range(2, 4);
    T = c + 3 + K * FAST_P;
    for (k = 1; k < K; k++) expect_pulse(c + 3 + k * FAST_P, c + 3 + k * FAST_P);
    until_cyc(T - 1);
    bus.halt_req = 1'b1;
    cycles(1);
    bus.halt_req = 1'b0;
    check("halt_state", bus.state, 3);
    check("halt_no_pulse", bus.cpu_en, 0);
    for (int i = 0; i < 50; i++) begin
      bus.halt_req = 1'($urandom_range(0, 1));
      cycles(1);
    end
    bus.halt_req = 1'b0;
    check("halt_held_state", bus.state, 3);
    drained("halt_drain");
    bus.mode = 2'b00;
    cycles(3);
    check("halt_exit_state", bus.state, 0);

    // Asynchronous reset in the middle of the fifth pulse.
    reset_n = 1'b0;
    cycles(2);
    exp_q.delete();
    model_cnt = 16'd0;
    reset_n = 1'b1;
    cycles(5);
    c = cyc;
    bus.mode = 2'b01;
    for (k = 1; k < 5; k++) expect_pulse(c + 3 + k * FAST_P, c + 3 + k * FAST_P);
    until_cyc(c + 3 + 5 * FAST_P);
    check("mid_cpu_en", bus.cpu_en, 1);
    check("mid_en_count", bus.en_count, 5);
    drained("mid_drain");
    #4 reset_n = 1'b0;
    #1;
    check("async_cpu_en", bus.cpu_en, 0);
    check("async_en_count", bus.en_count, 0);
    check("async_state", bus.state, 0);
    cycles(3);
    model_cnt = 16'd0;
    r = cyc;
    reset_n = 1'b1;
    e = -1;
    for (int i = 0; i < 20 && e < 0; i++) begin
      cycles(1);
      if (bus.state == 2'd1) e = cyc;
    end
    checks++;
    if (e < 0) begin
      errors++;
      $display("FAIL reentry_timeout actual=no RUN required=RUN within 20 cycles");
    end else begin
      if (e - r < 3 || e - r > 5) begin
        errors++;
        $display("FAIL reentry_latency actual=%0d required=3..5", e - r);
      end
      expect_pulse(e + FAST_P, e + FAST_P);
      expect_pulse(e + 2 * FAST_P, e + 2 * FAST_P);
      until_cyc(e + 2 * FAST_P + 1);
      drained("reentry_drain");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
